// File: rtl/sim_status_pkg.sv
// Shared definitions for the simulation status responder:
// register map, FSM states, the timeout code and small decode helpers.
package sim_status_pkg;

  localparam logic [31:0] OFF_STATUS   = 32'h00;
  localparam logic [31:0] OFF_CONSOLE  = 32'h04;
  localparam logic [31:0] OFF_CYCLE_LO = 32'h08;
  localparam logic [31:0] OFF_CYCLE_HI = 32'h0C;
  localparam logic [31:0] OFF_TIMEOUT  = 32'h10;

  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_e;

  typedef enum logic [2:0] {
    SEL_STATUS, SEL_CONSOLE, SEL_CYCLE_LO, SEL_CYCLE_HI, SEL_TIMEOUT, SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [31:0] byte_off);
    case (byte_off)
      OFF_STATUS:   return SEL_STATUS;
      OFF_CONSOLE:  return SEL_CONSOLE;
      OFF_CYCLE_LO: return SEL_CYCLE_LO;
      OFF_CYCLE_HI: return SEL_CYCLE_HI;
      OFF_TIMEOUT:  return SEL_TIMEOUT;
      default:      return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_status_dev_if.sv
// Request/response bus between the SoC data bus and the status responder.
interface sim_status_dev_if #(parameter int ADDR_W = 8);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero while empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; emptiness comes from the pointers and rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sim_status_dev.sv
// Memory-mapped pass/fail/timeout responder with cycle counter and console FIFO.
module sim_status_dev
  import sim_status_pkg::*;
#(
  parameter int          ADDR_W          = 8,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'd5000
) (
  input  logic             clk,
  input  logic             rst,
  sim_status_dev_if.slave  bus,
  output logic             char_valid,
  output logic [7:0]       char_data,
  input  logic             char_ready,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [31:0]      fail_code
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state_q, state_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] limit_q, limit_d, shadow_q, shadow_d;
  logic [31:0] fail_code_q, fail_code_d, rsp_rdata_q, rsp_rdata_d;
  logic        rsp_valid_q, done_q, pass_q, timeout_q;

  logic [ADDR_W-1:0] addr;
  reg_sel_e          sel;
  logic              accept, wr, rd, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign addr   = bus.req_addr;
  assign sel    = decode_reg(32'(addr) & ~32'h3);
  assign pop    = char_valid & char_ready;
  assign bus.req_ready = ~(bus.req_valid & bus.req_we & (sel == SEL_CONSOLE) & fifo_full & ~pop);
  assign accept = bus.req_valid & bus.req_ready;
  assign wr     = accept & bus.req_we & (bus.req_wstrb != 4'b0000);
  assign rd     = accept & ~bus.req_we;
  assign push   = wr & (sel == SEL_CONSOLE);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_console_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.req_wdata[7:0]),
    .pop   (pop),
    .rdata (char_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign char_valid    = ~fifo_empty;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign fail_code     = fail_code_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    shadow_d    = shadow_q;
    fail_code_d = fail_code_q;
    rsp_rdata_d = '0;

    // A STATUS write outranks a timeout match on the same edge; the counter stops on the finishing edge.
    if (state_q == ST_RUN) begin
      if (wr && sel == SEL_STATUS) begin
        state_d     = (bus.req_wdata == 32'd1) ? ST_PASS : ST_FAIL;
        fail_code_d = bus.req_wdata;
      end else if (limit_q != '0 && cnt_q == {32'd0, limit_q}) begin
        state_d     = ST_TIMEOUT;
        fail_code_d = TIMEOUT_CODE;
      end else begin
        cnt_d = cnt_q + 64'd1;
      end
    end

    if (wr && sel == SEL_TIMEOUT) limit_d = merge_bytes(limit_q, bus.req_wdata, bus.req_wstrb);

    if (rd) begin
      case (sel)
        SEL_STATUS:   rsp_rdata_d = fail_code_q;
        SEL_CONSOLE:  rsp_rdata_d = 32'(fifo_count);
        SEL_CYCLE_LO: begin
          rsp_rdata_d = cnt_q[31:0];
          shadow_d    = cnt_q[63:32];
        end
        SEL_CYCLE_HI: rsp_rdata_d = shadow_q;
        SEL_TIMEOUT:  rsp_rdata_d = limit_q;
        default:      rsp_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      limit_q     <= DEFAULT_TIMEOUT;
      shadow_q    <= '0;
      fail_code_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      shadow_q    <= shadow_d;
      fail_code_q <= fail_code_d;
      rsp_valid_q <= accept;
      rsp_rdata_q <= rsp_rdata_d;
      done_q      <= (state_d != ST_RUN);
      pass_q      <= (state_d == ST_PASS);
      timeout_q   <= (state_d == ST_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_sim_status_dev.sv
// Directed bench for sim_status_dev: status FSM, timeout, console FIFO, cycle snapshot, reset.
module tb_sim_status_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        done, pass, timeout;
  logic [31:0] fail_code;
  int          checks = 0;
  int          errors = 0;
  logic        rv;
  logic [31:0] rd;

  always #5 clk = ~clk;

  sim_status_dev_if #(.ADDR_W(8)) bus ();

  sim_status_dev #(.ADDR_W(8), .FIFO_DEPTH(4), .DEFAULT_TIMEOUT(32'd5000)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_code  (fail_code)
  );

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
  endtask

  // Leaves the bench at a falling edge with reset released; the next rising edge makes the count 1.
  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    char_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts and ends at a falling edge; returns the response seen in the cycle after acceptance.
  task automatic bus_op(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic rvalid, output logic [31:0] rdata);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    #1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL bus_stall: req_ready still %0b after %0d cycles, want 1", bus.req_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    rvalid = bus.rsp_valid;
    rdata  = bus.rsp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    char_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    checks++; if ({char_valid, char_data} !== 9'h0) begin errors++; $display("FAIL rst_char: got %b/%h want 0/00", char_valid, char_data); end
    checks++; if ({done, pass, timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {done, pass, timeout}); end
    checks++; if (fail_code !== 32'h0) begin errors++; $display("FAIL rst_fail_code: got %h want 0", fail_code); end
    rst = 1'b0;
    bus_op(1'b0, 8'h10, 32'h0, 4'h0, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'd5000) begin errors++; $display("FAIL rst_limit: got %0b/%0d want 1/5000", rv, rd); end
  endtask

  task automatic test_pass();
    do_reset();
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_pre_done: got %0b want 0", done); end
    bus_op(1'b1, 8'h00, 32'd1, 4'hF, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL pass_rsp: got %0b/%h want 1/0", rv, rd); end
    checks++; if ({done, pass, timeout} !== 3'b110) begin errors++; $display("FAIL pass_flags: got %b want 110", {done, pass, timeout}); end
    checks++; if (fail_code !== 32'd1) begin errors++; $display("FAIL pass_code: got %h want 1", fail_code); end
    repeat (5) @(negedge clk);
    bus_op(1'b0, 8'h08, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'd50) begin errors++; $display("FAIL pass_frozen_cnt: got %0d want 50", rd); end
    bus_op(1'b0, 8'h00, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL pass_status_rd: got %h want 1", rd); end
  endtask

  task automatic test_fail();
    do_reset();
    bus_op(1'b1, 8'h00, 32'h2A, 4'hF, rv, rd);
    checks++; if ({done, pass, timeout} !== 3'b100) begin errors++; $display("FAIL fail_flags: got %b want 100", {done, pass, timeout}); end
    checks++; if (fail_code !== 32'h2A) begin errors++; $display("FAIL fail_code: got %h want 2a", fail_code); end
    bus_op(1'b1, 8'h00, 32'd1, 4'hF, rv, rd);
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL fail_late_rsp: got %0b want 1", rv); end
    checks++; if ({done, pass, fail_code} !== {2'b10, 32'h2A}) begin errors++; $display("FAIL fail_sticky: got %b/%h want 10/2a", {done, pass}, fail_code); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus_op(1'b1, 8'h10, 32'd20, 4'hF, rv, rd);
    repeat (19) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_early: done %0b at count 20, want 0", done); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({done, pass, timeout} !== 3'b101) begin errors++; $display("FAIL to_flags: got %b want 101", {done, pass, timeout}); end
    checks++; if (fail_code !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_code: got %h want ffffffff", fail_code); end
    bus_op(1'b0, 8'h08, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL to_frozen_cnt: got %0d want 20", rd); end

    do_reset();
    bus_op(1'b1, 8'h10, 32'd0, 4'hF, rv, rd);
    repeat (10000) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_disabled: done %0b want 0", done); end

    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus_op(1'b1, 8'h10, 32'd5, 4'hF, rv, rd);
    repeat (30) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_past_limit: done %0b want 0", done); end
  endtask

  task automatic test_race();
    do_reset();
    bus_op(1'b1, 8'h10, 32'd20, 4'hF, rv, rd);
    repeat (19) @(posedge clk);
    @(negedge clk);
    bus_op(1'b1, 8'h00, 32'd1, 4'hF, rv, rd);
    checks++; if ({done, pass, timeout} !== 3'b110) begin errors++; $display("FAIL race_flags: got %b want 110", {done, pass, timeout}); end
    checks++; if (fail_code !== 32'd1) begin errors++; $display("FAIL race_code: got %h want 1", fail_code); end
  endtask

  task automatic test_console();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h42, 8'h43, 8'h44, 8'h45};
    do_reset();
    for (int i = 0; i < 4; i++) bus_op(1'b1, 8'h04, 32'h41 + i, 4'h1, rv, rd);
    checks++; if ({char_valid, char_data} !== {1'b1, 8'h41}) begin errors++; $display("FAIL con_head: got %b/%h want 1/41", char_valid, char_data); end
    bus_op(1'b0, 8'h04, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL con_count: got %0d want 4", rd); end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h04; bus.req_wdata = 32'h45; bus.req_wstrb = 4'h1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL con_stall: got %0b want 0", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL con_stall_hold: got %0b want 0", bus.req_ready); end
    char_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL con_release: got %0b want 1", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL con_5th_rsp: got %0b want 1", bus.rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({char_valid, char_data} !== {1'b1, exp_bytes[i]}) begin errors++; $display("FAIL con_order%0d: got %b/%h want 1/%h", i, char_valid, char_data, exp_bytes[i]); end
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL con_drained: got %0b want 0", char_valid); end
    bus_op(1'b1, 8'h00, 32'h7, 4'hF, rv, rd);
    bus_op(1'b1, 8'h04, 32'h5A, 4'h1, rv, rd);
    checks++; if ({rv, char_valid, char_data} !== {2'b11, 8'h5A}) begin errors++; $display("FAIL con_after_done: got %b%b/%h want 11/5a", rv, char_valid, char_data); end
    @(posedge clk);
    @(negedge clk);
    bus_op(1'b1, 8'h04, 32'h55, 4'h0, rv, rd);
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL con_zero_strb: got %0b want 0", char_valid); end
  endtask

  task automatic test_map();
    do_reset();
    bus_op(1'b0, 8'h13, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'd5000) begin errors++; $display("FAIL map_low_bits: got %0d want 5000", rd); end
    bus_op(1'b0, 8'h20, 32'h0, 4'h0, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL map_unmapped_rd: got %0b/%h want 1/0", rv, rd); end
    bus_op(1'b1, 8'h24, 32'h1, 4'hF, rv, rd);
    checks++; if (rv !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL map_unmapped_wr: got rsp %0b done %0b want 1/0", rv, done); end
    bus_op(1'b1, 8'h00, 32'h1, 4'h0, rv, rd);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL map_status_nostrb: done %0b want 0", done); end
    bus_op(1'b1, 8'h10, 32'hAABB_CCDD, 4'h1, rv, rd);
    bus_op(1'b0, 8'h10, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'h0000_13DD) begin errors++; $display("FAIL map_strb_merge: got %h want 000013dd", rd); end
  endtask

  task automatic test_cycle_snapshot();
    do_reset();
    bus_op(1'b1, 8'h10, 32'd0, 4'hF, rv, rd);
    force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    bus_op(1'b0, 8'h08, 32'h0, 4'h0, rv, rd);
    release dut.cnt_q;
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_lo: got %h want ffffffff", rd); end
    bus_op(1'b0, 8'h0C, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL snap_hi: got %h want 1", rd); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'd5000) begin errors++; $display("FAIL b2b_first: got %0b/%0d want 1/5000", bus.rsp_valid, bus.rsp_rdata); end
    bus.req_addr = 8'h08;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'd1) begin errors++; $display("FAIL b2b_second: got %0b/%0d want 1/1", bus.rsp_valid, bus.rsp_rdata); end
    idle_bus();
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_op(1'b1, 8'h00, 32'd1, 4'hF, rv, rd);
    bus_op(1'b1, 8'h04, 32'h33, 4'h1, rv, rd);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h00;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_bus();
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== 33'h0) begin errors++; $display("FAIL mid_rsp: got %0b/%h want 0/0", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if ({char_valid, char_data, done, pass, timeout} !== 12'h0) begin errors++; $display("FAIL mid_outs: got %b/%h/%b want 0/00/000", char_valid, char_data, {done, pass, timeout}); end
    checks++; if (fail_code !== 32'h0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_code: got %h/%0b want 0/1", fail_code, bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus_op(1'b0, 8'h10, 32'h0, 4'h0, rv, rd);
    checks++; if (rd !== 32'd5000) begin errors++; $display("FAIL mid_limit: got %0d want 5000", rd); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_bus();
    char_ready = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_race();
    test_console();
    test_map();
    test_cycle_snapshot();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_status_dev.md
# sim_status_dev

Memory-mapped test-status responder on the SoC data bus, the core-side end of the pass/fail handshake used by simulation benches. Firmware writes a status word to finish a test and writes console characters through a small FIFO. The block counts cycles and raises a timeout if firmware never reports. Its `done`/`pass`/`timeout` outputs give a bench or FPGA LEDs one place to watch, without peeking at register-file internals.

## Interface
- `ADDR_W`, default 8: byte-address bits decoded (offset within the device window).
- `FIFO_DEPTH`, default 4: console FIFO entries (power of two, ≥2).
- `DEFAULT_TIMEOUT`, default 5000: reset value of the timeout limit, in cycles. Limit 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: bus request valid.
- `req_ready` out 1: device can accept the request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: byte offset. Bits [1:0] are ignored.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: byte enables. Writes with `req_wstrb == 0` have no effect.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: read data, valid with `rsp_valid`. Value is 0 for writes.
- `char_valid` out 1: console FIFO not empty.
- `char_data` out 8: head of the console FIFO.
- `char_ready` in 1: consumer pops the head when `char_valid & char_ready`.
- `done` out 1: test finished, by report or by timeout.
- `pass` out 1: finished with status word == 1.
- `timeout` out 1: finished by timeout.
- `fail_code` out 32: status word written, or 0xFFFF_FFFF on timeout.

## Operation
- Register map (word offsets):
  - 0x00 STATUS: write only; reads return `fail_code`.
  - 0x04 CONSOLE: write pushes `wdata[7:0]`; reads return FIFO count.
  - 0x08 CYCLE_LO: read only. Reading it snapshots the upper 32 bits into a shadow register.
  - 0x0C CYCLE_HI: returns the shadow value.
  - 0x10 TIMEOUT: read/write limit.
  - Unmapped offsets: reads return 0, writes are ignored, and a response is still given.
- State machine states: RUN, PASS, FAIL, TIMEOUT. Reset state is RUN.
  - RUN → PASS on a STATUS write with `wdata == 1`.
  - RUN → FAIL on a STATUS write with any other value, including 0.
  - RUN → TIMEOUT when limit ≠ 0 and the cycle counter equals the limit.
  - PASS, FAIL and TIMEOUT are sticky until reset. STATUS writes in those states are acknowledged and ignored.
- If a STATUS write and a timeout match occur in the same cycle, the STATUS write wins.
- Outputs derived from state:
  - `done` = state ≠ RUN.
  - `pass` = state == PASS.
  - `timeout` = state == TIMEOUT.
- Cycle counter: 64 bits. It increments every cycle in RUN and freezes once `done` is set. Wrap-around is a plain modulo 2^64.
- Writing TIMEOUT with a value ≤ the current count does not trigger a timeout (equality compare only). Firmware uses this to extend or disable the timeout.
- Console FIFO:
  - A write to CONSOLE while the FIFO is full is stalled: `req_ready` = 0 for that request only.
  - Push and pop in the same cycle is allowed when full or empty. Occupancy stays the same when full; when empty, the pushed byte appears on `char_data` the next cycle.
  - Console writes remain accepted after `done`.
- Reset mid-operation: all state returns to reset values at once. The FIFO is emptied and any in-flight response is dropped.

## Timing
- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0.
  - `char_valid`=0, `char_data`=0.
  - `done`=`pass`=`timeout`=0, `fail_code`=0.
  - Cycle counter = 0, limit = `DEFAULT_TIMEOUT`.
- A request is accepted on a rising edge with `req_valid & req_ready`. `rsp_valid` is high the next cycle, exactly one cycle long. Back-to-back requests give back-to-back responses.
- `req_ready` is combinational: 0 only for a CONSOLE write while the FIFO is full.
- State outputs update in the cycle after the accepting or matching edge.
- Reads return register values as of the accept edge.

## Structure
- Shared package `sim_status_pkg`: register offset constants, state enum, and the 0xFFFF_FFFF timeout code.
- One sub-module, `sync_fifo` (width 8, depth `FIFO_DEPTH`), for the console buffer. Decode, counter and FSM live in the top.

## Test plan
- Write STATUS=1 at cycle 50 → `done`=`pass`=1 one cycle later, `fail_code`=1, counter frozen at 50.
- Write STATUS=0x2A → `done`=1, `pass`=0, `fail_code`=0x2A. A later STATUS=1 write is ignored.
- Limit=20, no writes → `timeout`=`done`=1 after count 20, `fail_code`=0xFFFF_FFFF. Limit=0 run for 10 000 cycles → `done` stays 0.
- STATUS write in the same cycle as the timeout match → PASS, `timeout`=0.
- Push 5 bytes with `char_ready`=0 and depth 4 → 5th write sees `req_ready`=0. Raise `char_ready` → bytes emerge in order and the 5th is accepted.
- Force the counter to 0x0000_0001_FFFF_FFFF, read CYCLE_LO then CYCLE_HI → consistent pair. Assert reset mid-response → `rsp_valid`=0 and all outputs return to reset values.
